syst_skew_feeder: RTL and testbench
===================================

// Module: syst_skew_feeder
// PURPOSE
// - Upstream feeder for the systolic array: accepts one activation vector (one x per row) per
//   handshake and emits it diagonally skewed, so row r reaches its first node r cycles after row 0.
// - Drives x_i/valid_i of the left-column syst_node instances.
// - Frames tiles with last_i. Blocks new input while the skew drains, then pulses done_o.
// PARAMETERS
// - ROWS     4  number of array rows (>=1); row r has delay depth r+1
// - X_WIDTH  8  activation width, matches syst_node X_WIDTH
// PORTS
// - clk_i     in   1              single clock, all state on posedge
// - rst_ni    in   1              reset, synchronous, active-low
// - valid_i   in   1              upstream vector valid
// - ready_o   out  1              feeder can accept; transfer when valid_i && ready_o
// - last_i    in   1              qualifies the transferred vector as the last of a tile
// - x_vec_i   in   ROWS*X_WIDTH   row r occupies bits [r*X_WIDTH +: X_WIDTH]
// - x_o       out  ROWS*X_WIDTH   skewed activations, same packing, to array row r
// - valid_o   out  ROWS           per-row valid, to syst_node valid_i of row r
// - busy_o    out  1              any valid_o bit pending in the delay lines, or state==DRAIN
// - done_o    out  1              1-cycle pulse: last row of the tile's last vector is on x_o
// BEHAVIOUR
// - Reset (rst_ni==0 at a posedge): all delay stages cleared (data 0, valid 0); state=STREAM; cnt=0.
//   Reset values: ready_o=1, x_o=0, valid_o=0, busy_o=0, done_o=0.
//   Reset mid-tile discards in-flight vectors and raises no done_o.
// - Accept = valid_i && ready_o.
// - Delay lines always shift every cycle; there is no downstream backpressure because syst_node
//   has none.
// - Stage 0 of each row loads x_vec_i row slice and valid=1 on accept. Otherwise it loads data 0
//   and valid 0 (bubble; data is zeroed for deterministic waveforms).
// - Latency: a vector accepted at edge t drives valid_o[r]=1 with its row r data during cycle t+r+1.
// - valid_o[r] and x_o[r] are register outputs; no combinational path from inputs.
// - FSM (2 states):
//   STREAM: ready_o=1.
//     Accept with last_i=1 -> DRAIN, cnt<=ROWS-1.
//     Accept with last_i=0 -> stay.
//   DRAIN: ready_o=0; cnt decrements each cycle.
//     done_o = (state==DRAIN && cnt==0), combinational from registers.
//     At cnt==0 -> STREAM at the next edge.
// - Timing for last accepted at t: ready_o low in cycles t+1..t+ROWS; done_o high in cycle t+ROWS,
//   coincident with valid_o[ROWS-1]; ready_o high again in cycle t+ROWS+1.
// - ROWS==1: DRAIN lasts one cycle, with cnt=0 on entry and done_o high at t+1.
// - valid_i with ready_o=0: no transfer; upstream holds. The feeder does not latch the vector.
// - last_i is ignored unless accepted. Back-to-back tiles incur exactly ROWS stall cycles.
// - cnt width is $clog2(ROWS)+1; it never wraps because it is only loaded on entry to DRAIN.
// STRUCTURE
// - syst_pkg: typedef enum logic {ST_STREAM, ST_DRAIN} feeder_state_t; default ROWS/X_WIDTH
//   localparams shared with the array top.
// - Sub-module syst_delay_line #(DEPTH, WIDTH):
//   - shift register of {valid, data};
//   - sync active-low clear;
//   - one instance per row, generated with DEPTH=r+1.
// - busy_o = |(valid bits of all delay stages) || state==ST_DRAIN.
// TESTING (ROWS=4, X_WIDTH=8)
// - Reset: hold rst_ni=0 for 3 cycles with valid_i=1 -> x_o=0, valid_o=0, ready_o=1, done_o=0
//   throughout; no output until 1 cycle after release plus accept.
// - Single vector {8'h44,8'h33,8'h22,8'h11}, last_i=1, accepted at t:
//   - valid_o=4'b0001/0010/0100/1000 in cycles t+1..t+4;
//   - row data 11,22,33,44 respectively;
//   - ready_o=0 t+1..t+4; done_o only at t+4.
// - Streaming: 3 vectors back-to-back, last on the 3rd:
//   - valid_o[0] high t+1..t+3, valid_o[3] high t+4..t+6;
//   - done_o at t+6; ready_o low t+3..t+6.
// - Gapped input: valid_i pattern 1,0,1 (last on 2nd) -> bubble appears diagonally, e.g.
//   valid_o[2] = 1,0,1 in cycles t+3..t+5, with x_o row 2 = 0 in the bubble.
// - Blocked input: valid_i=1 held during DRAIN with different data -> no transfer until ready_o
//   returns; that data appears at row 0 exactly 1 cycle after re-accept.
// - Reset mid-drain: assert rst_ni=0 at t+2 -> next cycle all valid_o=0, busy_o=0, ready_o=1;
//   done_o never pulses for that tile.

Source files
------------

// File: rtl/syst_skew_feeder_pkg.sv
// Shared types and default geometry for the
// systolic-array skew feeder.
package syst_skew_feeder_pkg;

  localparam int unsigned ROWS_D    = 4;
  localparam int unsigned X_WIDTH_D = 8;

  typedef enum logic {
    ST_STREAM,
    ST_DRAIN
  } feeder_state_t;

endpackage

// File: rtl/syst_skew_feeder_if.sv
// Upstream vector handshake into the skew feeder.
// Signal names are as seen from the feeder side.
interface syst_skew_feeder_if
  import syst_skew_feeder_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_D,
  parameter int unsigned X_WIDTH = X_WIDTH_D
);

  logic                    valid_i;
  logic                    ready_o;
  logic                    last_i;
  logic [ROWS*X_WIDTH-1:0] x_vec_i;

  modport master (
    output valid_i,
    output last_i,
    output x_vec_i,
    input  ready_o
  );

  modport slave (
    input  valid_i,
    input  last_i,
    input  x_vec_i,
    output ready_o
  );

endinterface

// File: rtl/syst_skew_feeder_delay_line.sv
// Fixed-depth shift register of {valid, data}
// with synchronous active-low clear.
module syst_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             any_valid_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      dat_q[0] <= data_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o     = vld_q[DEPTH-1];
  assign data_o      = dat_q[DEPTH-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/syst_skew_feeder.sv
// Diagonal skew feeder: row r of each accepted
// vector reaches the array r cycles after row 0.
module syst_skew_feeder
  import syst_skew_feeder_pkg::*;
#(
  parameter int unsigned ROWS    = ROWS_D,
  parameter int unsigned X_WIDTH = X_WIDTH_D
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  syst_skew_feeder_if.slave       up_if,
  output logic [ROWS*X_WIDTH-1:0] x_o,
  output logic [ROWS-1:0]         valid_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned CNT_W = $clog2(ROWS) + 1;

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0]  any_v;
  logic             accept;

  assign up_if.ready_o = (state_q == ST_STREAM);
  assign accept = up_if.valid_i && up_if.ready_o;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [X_WIDTH-1:0] row_in;
    // bubbles carry zero data
    assign row_in = accept
      ? up_if.x_vec_i[r*X_WIDTH +: X_WIDTH]
      : '0;

    syst_delay_line #(
      .DEPTH (r + 1),
      .WIDTH (X_WIDTH)
    ) u_line (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (accept),
      .data_i      (row_in),
      .valid_o     (valid_o[r]),
      .data_o      (x_o[r*X_WIDTH +: X_WIDTH]),
      .any_valid_o (any_v[r])
    );
  end

  assign busy_o = (|any_v) || (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    unique case (state_q)
      ST_STREAM: begin
        if (accept && up_if.last_i) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(ROWS - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = ST_STREAM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_STREAM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_syst_skew_feeder.sv
// Directed bench for syst_skew_feeder, ROWS=4,
// X_WIDTH=8, hand-computed expected values.
module tb_syst_skew_feeder;

  localparam int unsigned ROWS = 4;
  localparam int unsigned XW   = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] x_o;
  logic [3:0]  valid_o;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  syst_skew_feeder_if #(
    .ROWS    (ROWS),
    .X_WIDTH (XW)
  ) up_if ();

  syst_skew_feeder #(
    .ROWS    (ROWS),
    .X_WIDTH (XW)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .up_if   (up_if),
    .x_o     (x_o),
    .valid_o (valid_o),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  // cycle k after accept edge t is index k-1
  logic [3:0] STR_VO [7] = '{4'b0001, 4'b0011,
    4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] GAP_VO [7] = '{4'b0001, 4'b0010,
    4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};
  bit TL_RDY [7] = '{1, 1, 0, 0, 0, 0, 1};
  bit TL_DN  [7] = '{0, 0, 0, 0, 0, 1, 0};

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        v,
    input logic        l,
    input logic [31:0] x
  );
    up_if.valid_i = v;
    up_if.last_i  = l;
    up_if.x_vec_i = x;
  endtask

  task automatic chk_cyc(
    input string      tag,
    input logic [3:0] vo,
    input bit         rdy,
    input bit         dn
  );
    check({tag, "/valid_o"}, 32'(valid_o), 32'(vo));
    check({tag, "/ready_o"}, 32'(up_if.ready_o), 32'(rdy));
    check({tag, "/done_o"}, 32'(done), 32'(dn));
  endtask

  logic [31:0] vec [3];

  initial begin
    // reset with valid_i asserted
    drive(1'b1, 1'b0, 32'hDEADBEEF);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst/x_o", x_o, 32'h0);
      chk_cyc("rst", 4'b0000, 1'b1, 1'b0);
      check("rst/busy", 32'(busy), 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    check("rel/valid_o", 32'(valid_o), 32'h0);

    // single vector, last
    drive(1'b1, 1'b1, 32'h44332211);
    step();
    drive(1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      chk_cyc("single", 4'(1 << (k - 1)), 1'b0, k == 4);
      check("single/x_o", x_o,
            (32'h11 * k) << ((k - 1) * 8));
      step();
    end
    chk_cyc("single/end", 4'b0000, 1'b1, 1'b0);
    check("single/busy", 32'(busy), 32'h0);

    // three back-to-back vectors, last on third
    vec[0] = 32'h04030201;
    vec[1] = 32'h14131211;
    vec[2] = 32'h24232221;
    for (int k = 0; k < 7; k++) begin
      if (k < 3) drive(1'b1, k == 2, vec[k]);
      else       drive(1'b0, 1'b0, 32'h0);
      step();
      chk_cyc("stream", STR_VO[k], TL_RDY[k], TL_DN[k]);
      if (k == 3) check("stream/x_o", x_o, 32'h04132200);
    end
    check("stream/busy", 32'(busy), 32'h0);

    // gapped: 1,0,1 with last on the second vector
    vec[0] = 32'h34333231;
    vec[2] = 32'h54535251;
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      drive(1'b1, 1'b0, vec[0]);
      else if (k == 2) drive(1'b1, 1'b1, vec[2]);
      else             drive(1'b0, 1'b1, 32'hFFFFFFFF);
      step();
      chk_cyc("gap", GAP_VO[k], TL_RDY[k], TL_DN[k]);
      if (k == 2) check("gap/row2", 32'(x_o[23:16]), 32'h33);
      if (k == 3) check("gap/row2", 32'(x_o[23:16]), 32'h00);
      if (k == 4) check("gap/row2", 32'(x_o[23:16]), 32'h53);
    end

    // blocked input held during drain
    drive(1'b1, 1'b1, 32'h64636261);
    step();
    check("blk/v0", 32'(valid_o[0]), 32'h1);
    check("blk/row0", 32'(x_o[7:0]), 32'h61);
    check("blk/rdy", 32'(up_if.ready_o), 32'h0);
    drive(1'b1, 1'b0, 32'h74737271);
    for (int k = 2; k <= 5; k++) begin
      step();
      check("blk/v0", 32'(valid_o[0]), 32'h0);
      check("blk/rdy", 32'(up_if.ready_o), 32'(k == 5));
      check("blk/done", 32'(done), 32'(k == 4));
    end
    step();
    drive(1'b0, 1'b0, 32'h0);
    check("blk/acc_v0", 32'(valid_o[0]), 32'h1);
    check("blk/acc_row0", 32'(x_o[7:0]), 32'h71);
    for (int k = 0; k < 4; k++) step();
    check("blk/idle", 32'(valid_o), 32'h0);

    // reset in the middle of a drain
    drive(1'b1, 1'b1, 32'h84838281);
    step();
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("mid/done", 32'(done), 32'h0);
    rst_n = 1'b0;
    step();
    chk_cyc("mid/rst", 4'b0000, 1'b1, 1'b0);
    check("mid/busy", 32'(busy), 32'h0);
    check("mid/x_o", x_o, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("mid/no_done", 32'(done), 32'h0);
      check("mid/no_vo", 32'(valid_o), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
